// File: rtl/gray_counter.sv
// gray_counter: N-bit Gray-code sequence generator behind a valid/ready handshake.
// Latency: 1 cycle from load, from rst release with en, or from a handshake to the next presented code.
// Backpressure: while out_valid=1 and out_ready=0, gray_out and out_valid hold; en and up_dn are ignored.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   en         permits presenting a new code
//   up_dn      step direction: 1 = increment, 0 = decrement
//   load       synchronous load strobe; loses only to rst
//   load_bin   binary start value taken when load=1
//   gray_out   registered Gray code, always gray(bin_cnt)
//   out_valid  gray_out holds a code not yet consumed
//   out_ready  downstream accepts gray_out this cycle
//   wrap       one-cycle pulse while the post-wrap code is presented
module gray_counter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up_dn,
  input  logic         load,
  input  logic [N-1:0] load_bin,
  output logic [N-1:0] gray_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         wrap
);

  localparam logic [N-1:0] ONE      = N'(1);
  localparam logic [N-1:0] ALL_ONES = {N{1'b1}};

  logic [N-1:0] bin_cnt;
  logic [N-1:0] bin_nxt;
  logic         wrap_nxt;
  logic         hs;

  function automatic logic [N-1:0] to_gray(input logic [N-1:0] x);
    return x ^ (x >> 1);
  endfunction

  assign hs = out_valid && out_ready;

  // Next step value and whether that step crosses the modulo boundary.
  always_comb begin
    bin_nxt  = bin_cnt;
    wrap_nxt = 1'b0;
    if (up_dn) begin
      bin_nxt  = bin_cnt + ONE;
      wrap_nxt = (bin_cnt == ALL_ONES);
    end else begin
      bin_nxt  = bin_cnt - ONE;
      wrap_nxt = (bin_cnt == '0);
    end
  end

  // gray_out is written on the same edge as bin_cnt so it never lags it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_cnt   <= '0;
      gray_out  <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else if (load) begin
      // A coincident handshake still consumes the current code; the step is dropped.
      bin_cnt   <= load_bin;
      gray_out  <= to_gray(load_bin);
      out_valid <= 1'b1;
      wrap      <= 1'b0;
    end else if (hs) begin
      // With en=0 the stepped code is kept but not presented until en returns.
      bin_cnt   <= bin_nxt;
      gray_out  <= to_gray(bin_nxt);
      out_valid <= en;
      wrap      <= wrap_nxt;
    end else if (!out_valid && en) begin
      out_valid <= 1'b1;
      wrap      <= 1'b0;
    end else begin
      wrap      <= 1'b0;
    end
  end

endmodule

// File: doc/gray_counter.md
# gray_counter

Parameterised Gray-code sequence generator that sits directly upstream of the Gray-to-binary converter. It produces one N-bit Gray code per accepted transfer over a valid/ready handshake. It supports up/down counting, synchronous load of a binary start value, and a wrap indicator. Consecutive presented codes always differ in exactly one bit, except across a load.

## Interface
- N, default 4, code width in bits; legal range N >= 2
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- en  input  1  generate-enable; permits presenting a new code
- up_dn  input  1  direction: 1 = increment, 0 = decrement; sampled at each step edge
- load  input  1  synchronous load strobe; highest priority after rst
- load_bin  input  N  binary value loaded when load=1
- gray_out  output  N  current Gray code, registered; always gray(bin_cnt)
- out_valid  output  1  gray_out holds a code not yet consumed
- out_ready  input  1  downstream accepts gray_out this cycle
- wrap  output  1  one-cycle pulse, high while the post-wrap code is presented

## Operation
- Internal state: binary register bin_cnt[N-1:0], output register gray_out, flag out_valid, flag wrap.
- gray_out is updated on the same edge as bin_cnt using gray(x) = x ^ (x >> 1). It is never combinational from bin_cnt, and it never lags bin_cnt.
- Handshake: hs = out_valid && out_ready.
- Priority per edge, highest first:
  - rst: bin_cnt=0, gray_out=0, out_valid=0, wrap=0.
  - load: bin_cnt=load_bin, gray_out=gray(load_bin), out_valid=1, wrap=0. Ignores en, out_ready and any coincident hs; the code being consumed that cycle counts as transferred.
  - hs: bin_cnt steps by +1 if up_dn=1 or -1 if up_dn=0, modulo 2^N. gray_out is updated to match and out_valid is set to en.
    - wrap=1 if the step went from 2^N-1 to 0 (up) or from 0 to 2^N-1 (down); otherwise wrap=0.
  - !out_valid && en: out_valid=1; bin_cnt and gray_out unchanged (the stored code is now presented); wrap=0.
  - Otherwise all state holds, and wrap=0.
- While out_valid=1 and out_ready=0, gray_out and out_valid hold regardless of en and up_dn.
- Each code is presented exactly once, in order. A step only happens on a handshake, so no code is skipped or repeated.
- Changing up_dn mid-sequence reverses the direction from the current code at the next hs.
- Codes are unsigned; there is no saturation.

## Timing
- Reset values: gray_out=0, out_valid=0, wrap=0.
- After rst is released with en=1, the first out_valid is high one edge later, presenting code 0.
- With en=1 and out_ready=1 held, throughput is one code per cycle. The next code appears on the edge of the handshake (zero bubble).
- Load to presented code: 1 cycle.
- wrap is high for exactly the one cycle in which the wrapped code (0 up, or all-ones binary down) is first presented, and is cleared on the next edge.
- With out_ready held low, wrap stays high until the next edge, which clears it.
- rst mid-operation overrides load, en and handshake on that edge.

## Test plan
- **Free run up, N=4:** after rst, en=1, out_ready=1, up_dn=1 → gray_out = 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000.
  - wrap=1 only on the cycle of the second 0000.
  - Every transition is Hamming distance 1.
  - The converter output fed from gray_out reads 0..15, 0.
- **Backpressure:** hold out_ready=0 for 3 cycles while 0011 is presented → gray_out=0011 and out_valid=1 throughout. out_ready=1 → next cycle shows 0010.
- **Down wrap:** load=1 with load_bin=0000 → gray_out=0000, out_valid=1. Then up_dn=0 with a handshake → gray_out=1000 (binary 15) and wrap=1 for one cycle.
- **Load priority:** load=1 with load_bin=0101 while en=1 and a handshake is pending → next cycle gray_out=0111, out_valid=1, wrap=0; the handshake step is ignored.
- **Enable gap:** handshake on 0110 with en=0 → out_valid=0 and internal code 0111 is held. Raise en → out_valid=1 with gray_out=0111, with no skipped or repeated code.
- **Reset mid-count:** assert rst together with load=1 while gray_out=1010 → next cycle gray_out=0000, out_valid=0, wrap=0.
